// File: rtl/rect_flow_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rect_flow_ctrl_pkg
// Shared types and sizing helpers for the stereo rectification admission
// controller. The FSM state enum lives here together with the functions
// that derive beats-per-line and counter widths from the image geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package rect_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_e;

  // Beats per image line.
  function automatic int bpl_f(input int width, input int nppc);
    return width / nppc;
  endfunction

  // Width of a counter that indexes 0..n-1 (at least one bit).
  function automatic int cnt_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that holds 0..depth inclusive.
  function automatic int credit_w_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rect_flow_ctrl_if.sv
// -----------------------------------------------------------------------------
// rect_flow_ctrl_if
// Groups the paired left/right AXI-stream sideband handshake, the datapath
// issue strobe with its generated flags, and the output FIFO pop strobe.
//   master : upstream/downstream environment (drives streams and fifo_pop)
//   slave  : rect_flow_ctrl (drives treadys and the pipe_* issue signals)
// -----------------------------------------------------------------------------
interface rect_flow_ctrl_if;

  logic s_axis_l_tvalid;
  logic s_axis_l_tuser;
  logic s_axis_l_tlast;
  logic s_axis_r_tvalid;
  logic s_axis_r_tuser;
  logic s_axis_r_tlast;
  logic s_axis_l_tready;
  logic s_axis_r_tready;
  logic pipe_en;
  logic pipe_tuser;
  logic pipe_tlast;
  logic fifo_pop;

  modport master (
    output s_axis_l_tvalid, s_axis_l_tuser, s_axis_l_tlast,
    output s_axis_r_tvalid, s_axis_r_tuser, s_axis_r_tlast,
    output fifo_pop,
    input  s_axis_l_tready, s_axis_r_tready,
    input  pipe_en, pipe_tuser, pipe_tlast
  );

  modport slave (
    input  s_axis_l_tvalid, s_axis_l_tuser, s_axis_l_tlast,
    input  s_axis_r_tvalid, s_axis_r_tuser, s_axis_r_tlast,
    input  fifo_pop,
    output s_axis_l_tready, s_axis_r_tready,
    output pipe_en, pipe_tuser, pipe_tlast
  );

endinterface

// File: rtl/rect_flow_ctrl_credit_chk.sv
// -----------------------------------------------------------------------------
// rect_credit_cnt_chk
// Property checker for the credit counter: the count never exceeds the FIFO
// depth and a decrement is never requested while no credit is available.
// Ports: i_clk, i_rst_n, i_dec (issue strobe), i_credits (current count).
// -----------------------------------------------------------------------------
module rect_credit_cnt_chk #(
  parameter int FIFO_DEPTH = 16,
  parameter int CRD_W      = 5
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic             i_dec,
  input logic [CRD_W-1:0] i_credits
);

  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_credits <= CRD_W'(FIFO_DEPTH));

  a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_dec |-> (i_credits != {CRD_W{1'b0}}));

endmodule

// File: rtl/rect_flow_ctrl_credit_cnt.sv
// -----------------------------------------------------------------------------
// rect_credit_cnt
// Saturating up/down credit counter tracking guaranteed output FIFO space.
// Resets to FIFO_DEPTH. i_dec consumes a credit, i_inc returns one; both in
// the same cycle leave the count unchanged. A return while already full is
// ignored.
// Ports: i_clk, i_rst_n (async, active-low), i_dec, i_inc, o_credits.
// -----------------------------------------------------------------------------
module rect_credit_cnt #(
  parameter int FIFO_DEPTH = 16,
  parameter int CRD_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dec,
  input  logic             i_inc,
  output logic [CRD_W-1:0] o_credits
);

  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(FIFO_DEPTH);

  logic [CRD_W-1:0] r_credits;
  logic [CRD_W-1:0] w_credits_nxt;
  logic             w_inc_eff;
  logic             w_dec_eff;

  // Next credit value with saturation at both ends.
  always_comb begin
    w_inc_eff     = i_inc & (r_credits != CRD_FULL);
    w_dec_eff     = i_dec & (r_credits != {CRD_W{1'b0}});
    w_credits_nxt = r_credits;
    case ({w_inc_eff, w_dec_eff})
      2'b10:   w_credits_nxt = r_credits + CRD_W'(1);
      2'b01:   w_credits_nxt = r_credits - CRD_W'(1);
      default: w_credits_nxt = r_credits;
    endcase
  end

  // Credit register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credits <= CRD_FULL;
    end else begin
      r_credits <= w_credits_nxt;
    end
  end

  assign o_credits = r_credits;

  rect_credit_cnt_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CRD_W      (CRD_W)
  ) u_chk (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_dec     (i_dec),
    .i_credits (r_credits)
  );

endmodule

// File: rtl/rect_flow_ctrl.sv
// -----------------------------------------------------------------------------
// rect_flow_ctrl
// Admission controller in front of the non-stallable rectification pipeline.
// Pairs left/right beats, issues them only when the output FIFO has a credit,
// aligns to start of frame, regenerates SOF/EOL from position counters and
// flags stream protocol errors.
// Ports:
//   aclk, aresetn   clock, async active-low reset
//   enable          level-sensitive run request
//   s_if (slave)    paired stream handshake, pipe issue strobe/flags, fifo_pop
//   busy            registered, state != IDLE
//   frame_cnt       completed frames (wrapping)
//   err_sof/eol/lr  one-cycle error pulses, registered one cycle after the beat
// -----------------------------------------------------------------------------
module rect_flow_ctrl
  import rect_flow_ctrl_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int NPPC       = 4,
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  rect_flow_ctrl_if.slave       s_if,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  err_sof,
  output logic                  err_eol,
  output logic                  err_lr
);

  localparam int BPL   = bpl_f(WIDTH, NPPC);
  localparam int COL_W = cnt_w_f(BPL);
  localparam int ROW_W = cnt_w_f(HEIGHT);
  localparam int CRD_W = credit_w_f(FIFO_DEPTH);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BPL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  // Without LATENCY+1 entries an in-flight beat could find the FIFO full.
  if (FIFO_DEPTH < LATENCY + 1) begin : g_depth_chk
    $error("rect_flow_ctrl: FIFO_DEPTH must be >= LATENCY+1");
  end
  if ((WIDTH % NPPC) != 0) begin : g_width_chk
    $error("rect_flow_ctrl: WIDTH must be a multiple of NPPC");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] w_next_col;
  logic [ROW_W-1:0] w_next_row;
  logic [COL_W-1:0] w_pos_col;
  logic [ROW_W-1:0] w_pos_row;
  logic [15:0]      r_frame_cnt;
  logic             r_busy;
  logic             r_err_sof;
  logic             r_err_eol;
  logic             r_err_lr;
  logic             w_err_sof;
  logic             w_err_eol;
  logic             w_err_lr;
  logic             w_both_v;
  logic             w_credit_ok;
  logic             w_tready;
  logic             w_issue;
  logic             w_frame_done;
  logic [CRD_W-1:0] w_credits;

  assign w_both_v    = s_if.s_axis_l_tvalid & s_if.s_axis_r_tvalid;
  assign w_credit_ok = (w_credits != {CRD_W{1'b0}});

  rect_credit_cnt #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CRD_W      (CRD_W)
  ) u_credit (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_dec     (w_issue),
    .i_inc     (s_if.fifo_pop),
    .o_credits (w_credits)
  );

  // FSM next state, handshake, error detection and position advance.
  always_comb begin
    w_next_state = r_state;
    w_tready     = 1'b0;
    w_issue      = 1'b0;
    w_pos_col    = {COL_W{1'b0}};
    w_pos_row    = {ROW_W{1'b0}};
    w_next_col   = r_col;
    w_next_row   = r_row;
    w_frame_done = 1'b0;
    w_err_sof    = 1'b0;
    w_err_eol    = 1'b0;
    w_err_lr     = 1'b0;

    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next_state = WAIT_SOF;
        end else begin
          w_next_state = IDLE;
        end
      end

      WAIT_SOF: begin
        if (!enable) begin
          w_next_state = IDLE;
        end else if (w_both_v && s_if.s_axis_l_tuser) begin
          // An SOF beat is held (not acked) until a credit is available.
          w_tready = w_credit_ok;
          w_issue  = w_credit_ok;
          if (w_credit_ok) begin
            w_next_state = ACTIVE;
          end else begin
            w_next_state = WAIT_SOF;
          end
        end else begin
          // Beats ahead of the first SOF are acked and dropped.
          w_tready = w_both_v;
        end
      end

      ACTIVE: begin
        w_tready = w_both_v & w_credit_ok;
        w_issue  = w_both_v & w_credit_ok;
        if (w_issue) begin
          // A stray SOF restarts the frame at this beat.
          if (s_if.s_axis_l_tuser &&
              !((r_row == {ROW_W{1'b0}}) && (r_col == {COL_W{1'b0}}))) begin
            w_err_sof = 1'b1;
            w_pos_col = {COL_W{1'b0}};
            w_pos_row = {ROW_W{1'b0}};
          end else begin
            w_pos_col = r_col;
            w_pos_row = r_row;
          end
          w_err_eol = s_if.s_axis_l_tlast != (w_pos_col == COL_LAST);
          w_err_lr  = (s_if.s_axis_l_tuser != s_if.s_axis_r_tuser) |
                      (s_if.s_axis_l_tlast != s_if.s_axis_r_tlast);
        end else begin
          w_err_sof = 1'b0;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    // Counters are authoritative: advance from the issued beat's position.
    if (w_issue) begin
      if (w_pos_col == COL_LAST) begin
        w_next_col = {COL_W{1'b0}};
        if (w_pos_row == ROW_LAST) begin
          w_frame_done = 1'b1;
          w_next_row   = {ROW_W{1'b0}};
          w_next_state = enable ? WAIT_SOF : IDLE;
        end else begin
          w_next_row = w_pos_row + ROW_W'(1);
        end
      end else begin
        w_next_col = w_pos_col + COL_W'(1);
        w_next_row = w_pos_row;
      end
    end else begin
      w_frame_done = 1'b0;
    end
  end

  // State, position, frame count, busy and error pulse registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_col       <= {COL_W{1'b0}};
      r_row       <= {ROW_W{1'b0}};
      r_frame_cnt <= 16'd0;
      r_busy      <= 1'b0;
      r_err_sof   <= 1'b0;
      r_err_eol   <= 1'b0;
      r_err_lr    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_col       <= w_next_col;
      r_row       <= w_next_row;
      r_frame_cnt <= w_frame_done ? (r_frame_cnt + 16'd1) : r_frame_cnt;
      r_busy      <= (w_next_state != IDLE);
      r_err_sof   <= w_err_sof;
      r_err_eol   <= w_err_eol;
      r_err_lr    <= w_err_lr;
    end
  end

  // Issue is zero-cycle: tready and pipe_en follow the current handshake.
  assign s_if.s_axis_l_tready = w_tready;
  assign s_if.s_axis_r_tready = w_tready;
  assign s_if.pipe_en         = w_issue;
  assign s_if.pipe_tuser      = w_issue & (w_pos_row == {ROW_W{1'b0}}) &
                                (w_pos_col == {COL_W{1'b0}});
  assign s_if.pipe_tlast      = w_issue & (w_pos_col == COL_LAST);

  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign err_sof   = r_err_sof;
  assign err_eol   = r_err_eol;
  assign err_lr    = r_err_lr;

endmodule

// File: tb/tb_rect_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rect_flow_ctrl
// Directed, table-driven bench for rect_flow_ctrl with a 16x4 image (BPL=4),
// FIFO_DEPTH=11, LATENCY=10. Inputs are driven 1 ns after the rising edge;
// outputs are sampled on the falling edge, so registered outputs reflect the
// previous cycle's beat.
// -----------------------------------------------------------------------------
module tb_rect_flow_ctrl;

  logic        clk;
  logic        aresetn;
  logic        enable;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_sof;
  logic        err_eol;
  logic        err_lr;

  int n_tests = 0;
  int n_fail  = 0;

  rect_flow_ctrl_if u_if ();

  rect_flow_ctrl #(
    .WIDTH      (16),
    .HEIGHT     (4),
    .NPPC       (4),
    .LATENCY    (10),
    .FIFO_DEPTH (11)
  ) dut (
    .aclk      (clk),
    .aresetn   (aresetn),
    .enable    (enable),
    .s_if      (u_if),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_sof   (err_sof),
    .err_eol   (err_eol),
    .err_lr    (err_lr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_v  = {en, l_tvalid, l_tuser, l_tlast, r_tvalid, r_tuser, r_tlast, fifo_pop}
  // exp_v = {tready, pipe_en, pipe_tuser, pipe_tlast, err_sof, err_eol, err_lr, busy}
  typedef struct {
    logic [7:0]  in_v;
    logic [7:0]  exp_v;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];

  int bp_pop [11] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int bp_pe  [11] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  function automatic void add(input logic [7:0] in_v, input logic [7:0] exp_v,
                              input logic [15:0] fc);
    vec_t v;
    v.in_v  = in_v;
    v.exp_v = exp_v;
    v.fc    = fc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] in_v);
    enable                = in_v[7];
    u_if.s_axis_l_tvalid  = in_v[6];
    u_if.s_axis_l_tuser   = in_v[5];
    u_if.s_axis_l_tlast   = in_v[4];
    u_if.s_axis_r_tvalid  = in_v[3];
    u_if.s_axis_r_tuser   = in_v[2];
    u_if.s_axis_r_tlast   = in_v[1];
    u_if.fifo_pop         = in_v[0];
  endtask

  // Drive one cycle's inputs after the rising edge, then wait for the falling edge.
  task automatic cycle(input logic [7:0] in_v);
    @(posedge clk);
    #1;
    drive(in_v);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".tready"}, int'(u_if.s_axis_l_tready), 0);
    chk({tag, ".pipe_en"}, int'(u_if.pipe_en), 0);
    chk({tag, ".pipe_tuser"}, int'(u_if.pipe_tuser), 0);
    chk({tag, ".pipe_tlast"}, int'(u_if.pipe_tlast), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, ".errs"}, int'({err_sof, err_eol, err_lr}), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    drive(8'b1000_0001);
    aresetn = 1'b1;
  endtask

  initial begin
    logic l;
    int   cnt;
    int   exp_cnt;
    logic rv;

    aresetn = 1'b0;
    drive(8'b0000_0000);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    aresetn = 1'b1;

    // ---------------- vector table ----------------
    add(8'b0000_0000, 8'b0000_0000, 16'd0);          // idle, enable low
    add(8'b1000_0001, 8'b0000_0000, 16'd0);          // enable -> WAIT_SOF
    for (int k = 0; k < 5; k++)                      // 5 beats before SOF dropped
      add(8'b1100_1001, 8'b1000_0001, 16'd0);
    add(8'b1110_1101, 8'b1110_0001, 16'd0);          // SOF beat issued
    for (int k = 1; k < 16; k++) begin               // rest of clean frame
      l = ((k % 4) == 3);
      add({1'b1, 1'b1, 1'b0, l, 1'b1, 1'b0, l, 1'b1},
          {1'b1, 1'b1, 1'b0, l, 1'b0, 1'b0, 1'b0, 1'b1}, 16'd0);
    end
    add(8'b1000_0001, 8'b0000_0001, 16'd1);          // back in WAIT_SOF, 1 frame
    add(8'b1110_1101, 8'b1110_0001, 16'd1);          // SOF of frame 2
    add(8'b1101_1011, 8'b1100_0001, 16'd1);          // tlast at col 1
    add(8'b1110_1101, 8'b1110_0101, 16'd1);          // tuser at col 2: restart; err_eol seen
    add(8'b1100_1001, 8'b1100_1001, 16'd1);          // col 1; err_sof seen
    add(8'b1100_1001, 8'b1100_0001, 16'd1);          // col 2
    add(8'b1101_1001, 8'b1101_0001, 16'd1);          // col 3, r_tlast missing
    for (int p = 4; p < 16; p++) begin               // enable dropped mid-frame
      l = ((p % 4) == 3);
      add({1'b0, 1'b1, 1'b0, l, 1'b1, 1'b0, l, 1'b1},
          {1'b1, 1'b1, 1'b0, l, 1'b0, 1'b0, (p == 4), 1'b1}, 16'd1);
    end
    add(8'b0100_1001, 8'b0000_0000, 16'd2);          // IDLE ignores beats
    add(8'b0000_0000, 8'b0000_0000, 16'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].in_v);
      chk($sformatf("v%0d.tready", i), int'(u_if.s_axis_l_tready), int'(vecs[i].exp_v[7]));
      chk($sformatf("v%0d.r_tready", i), int'(u_if.s_axis_r_tready), int'(vecs[i].exp_v[7]));
      chk($sformatf("v%0d.pipe_en", i), int'(u_if.pipe_en), int'(vecs[i].exp_v[6]));
      chk($sformatf("v%0d.pipe_tuser", i), int'(u_if.pipe_tuser), int'(vecs[i].exp_v[5]));
      chk($sformatf("v%0d.pipe_tlast", i), int'(u_if.pipe_tlast), int'(vecs[i].exp_v[4]));
      chk($sformatf("v%0d.err_sof", i), int'(err_sof), int'(vecs[i].exp_v[3]));
      chk($sformatf("v%0d.err_eol", i), int'(err_eol), int'(vecs[i].exp_v[2]));
      chk($sformatf("v%0d.err_lr", i), int'(err_lr), int'(vecs[i].exp_v[1]));
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vecs[i].exp_v[0]));
      chk($sformatf("v%0d.frame_cnt", i), int'(frame_cnt), int'(vecs[i].fc));
    end

    // ---------------- reset mid-frame ----------------
    cycle(8'b1000_0001);                             // IDLE -> WAIT_SOF
    cycle(8'b1110_1101);                             // SOF
    for (int k = 1; k < 6; k++) begin
      l = ((k % 4) == 3);
      cycle({1'b1, 1'b1, 1'b0, l, 1'b1, 1'b0, l, 1'b1});
    end
    pulse_reset();
    chk("rst_rel.busy", int'(busy), 0);
    @(negedge clk);
    chk("rst_resume.busy", int'(busy), 1);
    chk("rst_resume.tready", int'(u_if.s_axis_l_tready), 0);
    chk("rst_resume.errs", int'({err_sof, err_eol, err_lr}), 0);
    chk("rst_resume.frame_cnt", int'(frame_cnt), 0);

    // ---------------- back-pressure (no pops) ----------------
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle({1'b1, 1'b1, (i == 0), 1'b0, 1'b1, (i == 0), 1'b0, 1'b0});
      chk($sformatf("bp%0d.pipe_en", i), int'(u_if.pipe_en), int'(i < 11));
      chk($sformatf("bp%0d.tready", i), int'(u_if.s_axis_l_tready), int'(i < 11));
      cnt += int'(u_if.pipe_en);
    end
    chk("bp.accepted", cnt, 11);
    for (int j = 0; j < 11; j++) begin
      cycle({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'(bp_pop[j])});
      chk($sformatf("bp_pop%0d.pipe_en", j), int'(u_if.pipe_en), bp_pe[j]);
      cnt += int'(u_if.pipe_en);
    end
    chk("bp.total", cnt, 16);
    chk("bp.frame_cnt", int'(frame_cnt), 1);
    chk("bp.drop_tready", int'(u_if.s_axis_l_tready), 1);

    // ---------------- skewed valids ----------------
    pulse_reset();
    cycle(8'b1000_0001);                             // IDLE -> WAIT_SOF
    for (int i = 0; i < 3; i++) begin
      cycle(8'b1110_0001);                           // left SOF waiting for right
      chk($sformatf("skew%0d.tready", i), int'(u_if.s_axis_l_tready), 0);
      chk($sformatf("skew%0d.pipe_en", i), int'(u_if.pipe_en), 0);
    end
    cycle(8'b1110_1101);
    chk("skew_sof.pipe_en", int'(u_if.pipe_en), 1);
    chk("skew_sof.pipe_tuser", int'(u_if.pipe_tuser), 1);
    cnt     = 1;
    exp_cnt = 1;
    for (int j = 0; j < 12; j++) begin
      rv = ((j % 3) != 2);
      cycle({1'b1, 1'b1, 1'b0, 1'b0, rv, 1'b0, 1'b0, 1'b1});
      chk($sformatf("skew_b%0d.pipe_en", j), int'(u_if.pipe_en), int'(rv));
      chk($sformatf("skew_b%0d.r_tready", j), int'(u_if.s_axis_r_tready), int'(rv));
      cnt     += int'(u_if.pipe_en);
      exp_cnt += int'(rv);
    end
    chk("skew.count", cnt, exp_cnt);
    chk("skew.errs_sof", int'(err_sof), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_flow_ctrl.md
Name: rect_flow_ctrl

Overview:
- Admission/flow controller in front of the stereo rectification datapath (image buffer + bilinear interpolator).
- Pairs left/right input beats and issues them into the fixed-latency pipeline only when the downstream output FIFO has guaranteed space (credit scheme); the interpolator pipeline itself cannot stall.
- Also aligns frames on tuser, regenerates tuser/tlast from internal counters, and flags stream protocol errors.

Parameters:
WIDTH, 640, image width in pixels
HEIGHT, 480, image height in lines
NPPC, 4, pixels per beat; WIDTH % NPPC == 0
LATENCY, 10, pipeline depth in cycles from pipe_en to pipe_out_valid
FIFO_DEPTH, 16, output FIFO entries; must be >= LATENCY+1 (elaboration $error otherwise)
BPL, WIDTH/NPPC, beats per line (derived localparam)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
enable  in  1  run request, level-sensitive
s_axis_l_tvalid  in  1  left beat valid
s_axis_l_tuser  in  1  left start of frame
s_axis_l_tlast  in  1  left end of line
s_axis_r_tvalid  in  1  right beat valid
s_axis_r_tuser  in  1  right start of frame
s_axis_r_tlast  in  1  right end of line
s_axis_l_tready  out  1  accept, left
s_axis_r_tready  out  1  accept, right (always equal to left)
pipe_en  out  1  issue one beat into the datapath this cycle
pipe_tuser  out  1  generated SOF for the issued beat
pipe_tlast  out  1  generated EOL for the issued beat
fifo_pop  in  1  output FIFO handshake (m_tvalid & m_tready)
busy  out  1  state != IDLE
frame_cnt  out  16  completed frames, wraps at 65535 -> 0
err_sof  out  1  one-cycle pulse: unexpected tuser
err_eol  out  1  one-cycle pulse: tlast mismatch vs. column count
err_lr  out  1  one-cycle pulse: L/R tuser or tlast disagree on a paired beat

Behaviour:
- Reset (async assert, sync release): state IDLE; credits = FIFO_DEPTH; col/row = 0; frame_cnt = 0. All outputs 0 during and after reset until a state change. Reset mid-frame discards frame progress without error pulses.
- Pairing: both_v = l_tvalid & r_tvalid. A beat is consumed only when both_v is high; both treadys are identical.
- States:
  - IDLE: tready = 0. enable=1 -> WAIT_SOF.
  - WAIT_SOF: tready = both_v.
    - Beats without l_tuser are dropped (no pipe_en).
    - Beat with l_tuser and credits>0 -> issue it, col = 1, -> ACTIVE.
    - Beat with l_tuser and credits==0 -> tready = 0, hold.
    - enable=0 -> IDLE.
  - ACTIVE: tready = pipe_en = both_v & (credits != 0). Per issued beat, col increments. At col == BPL-1: col = 0 and row increments. At row == HEIGHT-1 and col == BPL-1: frame_cnt++, then -> WAIT_SOF if enable else IDLE. enable=0 mid-frame completes the frame first.
- Generated flags: pipe_tuser = (row==0 & col==0); pipe_tlast = (col==BPL-1). Both are combinational and valid only with pipe_en.
- Errors, checked in ACTIVE on issued beats:
  - l_tuser on a non-first beat -> err_sof; that beat is reissued as a new frame start (row = col = 0, pipe_tuser = 1). frame_cnt is not incremented.
  - l_tlast != (col==BPL-1) -> err_eol; the counters stay authoritative.
  - l_tuser != r_tuser or l_tlast != r_tlast -> err_lr; left controls sequencing.
  - Several errors may pulse in the same cycle.
- Credits:
  - Decrement on pipe_en; increment on fifo_pop; both in the same cycle -> unchanged.
  - Range 0..FIFO_DEPTH. fifo_pop at credits == FIFO_DEPTH is ignored (saturate).
  - Width $clog2(FIFO_DEPTH+1).
- Latency: pipe_en is asserted in the same cycle as the accepting handshake (zero-cycle issue). Issued data is therefore guaranteed FIFO space LATENCY cycles later.
- busy is registered, equal to (state != IDLE).

Decomposition:
- rect_pkg: state enum (IDLE, WAIT_SOF, ACTIVE); BPL and counter widths as functions of WIDTH, HEIGHT, NPPC.
- Sub-module rect_credit_cnt: the saturating up/down credit counter, with its own assertions (never underflows, never exceeds FIFO_DEPTH).
- Frame position counters stay in the top module.

Test Plan:
- Reset mid-frame: at row 3, col 50, pulse aresetn low for 1 cycle -> credits 16, all outputs 0, no error pulses; resumes in WAIT_SOF only if enable is high.
- Clean frame (WIDTH=16, HEIGHT=4, NPPC=4 -> BPL=4), fifo_pop every cycle, both valid continuously -> 16 pipe_en; pipe_tlast on beats 3,7,11,15; pipe_tuser on beat 0; frame_cnt 0 -> 1; no errors.
- Back-pressure (FIFO_DEPTH=11, LATENCY=10), fifo_pop held 0 -> exactly 11 beats accepted, then tready=0; one fifo_pop -> exactly one more beat accepted; simultaneous pop+issue leaves credits at 0.
- WAIT_SOF alignment: 5 beats without tuser, then tuser beat -> first 5 acked with no pipe_en; 6th issued with pipe_tuser=1.
- Errors: l_tuser at col 2 -> err_sof pulse and pipe_tuser=1 on that beat. l_tlast at col 1 -> err_eol. r_tlast=0 while l_tlast=1 at col 3 -> err_lr only.
- Skewed valids: r_tvalid lags l_tvalid by 3 cycles -> no tready and no pipe_en until both are high; the beat count stays matched.
